// File: rtl/frame_tx.sv
// Captures an 8-pixel-wide bitmap from a row/column sweep and, on frame end,
// streams a header byte followed by one byte per row over a valid/ready link.
module frame_tx #(
    parameter int          ROWS   = 8,
    parameter int          COLS   = 8,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       pix_valid,
    input  logic       pix,
    input  logic [3:0] col,
    input  logic [3:0] row,
    input  logic       frame_end,
    input  logic       clear,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       overrun
);

    localparam int         AW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [4:0] ROWS_L  = 5'(ROWS);
    localparam logic [4:0] COLS_L  = 5'(COLS);
    localparam logic [2:0] MSB_IDX = 3'(COLS - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    typedef enum logic [1:0] {
        CAPTURE  = 2'd0,
        SEND_HDR = 2'd1,
        SEND_ROW = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ROWS-1:0][7:0]   bitmap_q, bitmap_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   overrun_q, overrun_d;

    logic                   pix_in_range;
    logic [2:0]             bit_idx;

    // Column 0 lands in the MSB of the row byte.
    assign pix_in_range = ({1'b0, row} < ROWS_L) && ({1'b0, col} < COLS_L);
    assign bit_idx      = MSB_IDX - col[2:0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= CAPTURE;
            bitmap_q  <= '0;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitmap_q  <= bitmap_d;
            ptr_q     <= ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitmap_d  = bitmap_q;
        ptr_d     = ptr_q;
        overrun_d = overrun_q;

        case (state_q)
            CAPTURE: begin
                // A pixel arriving with frame_end is still written, so it joins this frame.
                if (clear) begin
                    bitmap_d = '0;
                end else if (pix_valid && pix_in_range) begin
                    bitmap_d[row[AW-1:0]][bit_idx] = pix;
                end
                if (frame_end) begin
                    state_d = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (pix_valid || frame_end) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    ptr_d   = '0;
                    state_d = SEND_ROW;
                end
            end
            SEND_ROW: begin
                if (pix_valid || frame_end) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    if (ptr_q == LAST_ROW) begin
                        bitmap_d = '0;
                        ptr_d    = '0;
                        state_d  = CAPTURE;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = CAPTURE;
            end
        endcase
    end

    // Outputs depend only on registered state, so tx_data holds through stalls.
    always_comb begin
        tx_valid = 1'b0;
        busy     = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            SEND_HDR: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = HEADER;
            end
            SEND_ROW: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = bitmap_q[ptr_q];
            end
            default: begin
                tx_valid = 1'b0;
                busy     = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_frame_tx.sv
// Randomized bench for frame_tx against a bitmap/byte-list reference model.
module tb_frame_tx;

    localparam int         ROWS = 8;
    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         NB   = ROWS + 1;

    logic       clk;
    logic       nrst;
    logic       pix_valid;
    logic       pix;
    logic [3:0] col;
    logic [3:0] row;
    logic       frame_end;
    logic       clear;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       overrun;

    frame_tx #(.ROWS(ROWS), .COLS(8), .HEADER(HDR)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pix_valid (pix_valid),
        .pix       (pix),
        .col       (col),
        .row       (row),
        .frame_end (frame_end),
        .clear     (clear),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] bm [ROWS];
    bit         ovr_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ROWS; i++) bm[i] = 8'h00;
    endtask

    task automatic idle_inputs();
        pix_valid = 1'b0;
        pix       = 1'b0;
        frame_end = 1'b0;
        clear     = 1'b0;
        tx_ready  = 1'b0;
    endtask

    // One capture-phase cycle; called and returns at a falling edge.
    task automatic drive(input logic v, input logic p, input int r, input int c,
                         input logic fe, input logic clr);
        pix_valid = v;
        pix       = p;
        row       = 4'(r);
        col       = 4'(c);
        frame_end = fe;
        clear     = clr;
        tx_ready  = 1'($urandom);
        @(posedge clk);
        if (clr) model_clear();
        else if (v && r < ROWS && c < 8) bm[r][7-c] = p;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic random_sweep(input int n);
        repeat (n) drive(1'(($urandom % 4) != 0), 1'($urandom), $urandom_range(0, 9),
                         $urandom_range(0, 9), 1'b0, 1'(($urandom % 20) == 0));
    endtask

    // mode 0: ready held high, 1: ready 1-0-0 pattern, 2: random ready.
    task automatic send_frame(input int mode, input bit disturb, input int abort_after);
        logic [7:0] exp [$];
        int idx, cyc, busy_cnt;
        bit rdy;
        exp.push_back(HDR);
        for (int r = 0; r < ROWS; r++) exp.push_back(bm[r]);
        idx = 0; cyc = 0; busy_cnt = 0;
        while (idx < NB && cyc < 300) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = 1'($urandom);
            endcase
            tx_ready = rdy;
            check_eq("tx_valid", 32'(tx_valid), 32'd1);
            check_eq("busy", 32'(busy), 32'd1);
            check_eq($sformatf("byte%0d", idx), 32'(tx_data), 32'(exp[idx]));
            if (disturb) begin
                pix_valid = 1'b1;
                pix       = 1'b1;
                row       = 4'($urandom_range(0, 7));
                col       = 4'($urandom_range(0, 7));
                frame_end = 1'($urandom);
                clear     = 1'($urandom);
                ovr_m     = 1'b1;
            end
            busy_cnt++;
            @(posedge clk);
            if (rdy) idx++;
            @(negedge clk);
            cyc++;
            if (abort_after > 0 && idx == abort_after) begin
                idle_inputs();
                return;
            end
        end
        idle_inputs();
        if (idx < NB) check_eq("frame_timeout", 32'(idx), 32'(NB));
        check_eq("tx_valid_after", 32'(tx_valid), 32'd0);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("tx_data_idle", 32'(tx_data), 32'h00);
        if (mode == 0) check_eq("busy_cycles", 32'(busy_cnt), 32'(NB));
        check_eq("overrun", 32'(overrun), 32'(ovr_m));
        model_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_tx_data"}, 32'(tx_data), 32'h00);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        nrst = 1'b0;
        row  = 4'd0;
        col  = 4'd0;
        idle_inputs();
        model_clear();
        ovr_m = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        nrst = 1'b1;
        @(negedge clk);

        // Corner pixels, then an empty frame to show the bitmap was cleared.
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 7, 7, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        send_frame(0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        send_frame(0, 0, 0);

        // Full sweep of ones, last pixel shares its cycle with frame_end.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 8; c++)
                drive(1, 1, r, c, 1'(r == ROWS - 1 && c == 7), 0);
        send_frame(1, 0, 0);

        // Out-of-range coordinates are dropped.
        drive(1, 1, 8, 3, 0, 0);
        drive(1, 1, 2, 9, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        send_frame(2, 0, 0);

        // Pixel with frame_end, then clear beating a simultaneous pixel.
        drive(1, 1, 3, 4, 1, 0);
        send_frame(0, 0, 0);
        drive(1, 1, 5, 5, 0, 0);
        drive(1, 1, 1, 2, 0, 1);
        drive(0, 0, 0, 0, 1, 0);
        send_frame(2, 0, 0);

        // Disturbances while busy raise sticky overrun without touching data.
        random_sweep(40);
        drive(0, 0, 0, 0, 1, 0);
        send_frame(2, 1, 0);
        random_sweep(30);
        drive(0, 0, 0, 0, 1, 0);
        send_frame(0, 0, 0);

        // Reset after the third transfer aborts the frame.
        random_sweep(30);
        drive(0, 0, 0, 0, 1, 0);
        send_frame(0, 0, 3);
        nrst = 1'b0;
        #1;
        check_reset_outputs("abort");
        ovr_m = 1'b0;
        model_clear();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        random_sweep(30);
        drive(0, 0, 0, 0, 1, 0);
        send_frame(2, 0, 0);

        // A few more random frames.
        for (int f = 0; f < 4; f++) begin
            random_sweep(50);
            drive(1'($urandom), 1'($urandom), $urandom_range(0, 9), $urandom_range(0, 9), 1, 0);
            send_frame(f % 3, 1'(f == 2), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
